// File: rtl/muldiv_seq.sv
// Iterative RV64M multiply/divide sequencer: one shift-add / restoring shift-subtract
// datapath shared by all M-extension ops, with RISC-V divide special cases and sign fixup.
module muldiv_seq #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  output logic            ready_out,
  input  logic [2:0]      op,
  input  logic            is_32instr,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            done,
  output logic [XLEN-1:0] c
);

  localparam int HW = XLEN / 2;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic                w_q, w_d, neg_q, neg_d, rneg_q, rneg_d;
  logic [XLEN-1:0]     opnd_q, opnd_d, shf_q, shf_d, c_q, c_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;

  function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v);
    return {{HW{v[HW-1]}}, v[HW-1:0]};
  endfunction

  function automatic logic [XLEN-1:0] cneg_x(input logic [XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cneg_2x(input logic [2*XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  // Operand preparation for the request currently presented
  logic signed [XLEN-1:0] a_ext, b_ext;
  logic                   w_zext, sgn_a, sgn_b, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0]        a_mag, b_mag, spec_res;

  always_comb begin
    w_zext = !op[2] || op[0];
    a_ext  = a;
    b_ext  = b;
    if (is_32instr) begin
      a_ext = w_zext ? {{HW{1'b0}}, a[HW-1:0]} : {{HW{a[HW-1]}}, a[HW-1:0]};
      b_ext = w_zext ? {{HW{1'b0}}, b[HW-1:0]} : {{HW{b[HW-1]}}, b[HW-1:0]};
    end
    sgn_a    = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    sgn_b    = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    a_neg    = sgn_a && a_ext[XLEN-1];
    b_neg    = sgn_b && b_ext[XLEN-1];
    a_mag    = cneg_x(a_ext, a_neg);
    b_mag    = cneg_x(b_ext, b_neg);
    div_zero = (b_ext == '0);
    div_ovf  = op[2] && !op[0] && (b_ext == '1) &&
               (a_ext == (is_32instr ? {{(HW+1){1'b1}}, {(HW-1){1'b0}}}
                                     : {1'b1, {(XLEN-1){1'b0}}}));
    if (div_zero) spec_res = op[1] ? a_ext : '1;
    else          spec_res = op[1] ? '0 : a_ext;
    if (is_32instr) spec_res = sext_w(spec_res);
  end

  // One datapath step plus the result that would be committed on the final step
  logic [XLEN:0]       mul_sum, div_rs;
  logic [2*XLEN-1:0]   mul_acc_n, prod;
  logic [XLEN-1:0]     mul_shf_n, div_sub, div_rem_n, div_shf_n, quo, rem, res;
  logic                div_ok;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (shf_q[0] ? {1'b0, opnd_q} : '0);
    mul_acc_n = {mul_sum, acc_q[XLEN-1:1]};
    mul_shf_n = {1'b0, shf_q[XLEN-1:1]};
    div_rs    = {acc_q[XLEN-1:0], shf_q[XLEN-1]};
    div_ok    = (div_rs >= {1'b0, opnd_q});
    div_sub   = div_rs[XLEN-1:0] - opnd_q;
    div_rem_n = div_ok ? div_sub : div_rs[XLEN-1:0];
    div_shf_n = {shf_q[XLEN-2:0], div_ok};
    prod      = cneg_2x(mul_acc_n, neg_q);
    quo       = cneg_x(div_shf_n, neg_q);
    rem       = cneg_x(div_rem_n, rneg_q);
    if (op_q[2])  res = op_q[1] ? rem : quo;
    // A 32-step multiply leaves its product in acc[95:32]; only the low word is kept
    else if (w_q) res = {{HW{1'b0}}, mul_acc_n[XLEN-1:HW]};
    else          res = (op_q[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    if (w_q) res = sext_w(res);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    w_d       = w_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    opnd_d    = opnd_q;
    shf_d     = shf_q;
    acc_d     = acc_q;
    c_d       = c_q;
    ready_out = (state_q == S_IDLE);
    done      = (state_q == S_DONE) && !flush;
    case (state_q)
      S_IDLE: begin
        if (valid_in && !flush) begin
          op_d   = op;
          w_d    = is_32instr;
          neg_d  = a_neg ^ b_neg;
          rneg_d = a_neg;
          if (op[2] && (div_zero || div_ovf)) begin
            state_d = S_DONE;
            c_d     = spec_res;
          end else begin
            state_d = S_BUSY;
            cnt_d   = is_32instr ? CNT_W'(HW) : CNT_W'(XLEN);
            acc_d   = '0;
            if (op[2]) begin
              opnd_d = b_mag;
              shf_d  = is_32instr ? {a_mag[HW-1:0], {HW{1'b0}}} : a_mag;
            end else begin
              opnd_d = a_mag;
              shf_d  = b_mag;
            end
          end
        end
      end
      S_BUSY: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          acc_d = op_q[2] ? {{XLEN{1'b0}}, div_rem_n} : mul_acc_n;
          shf_d = op_q[2] ? div_shf_n : mul_shf_n;
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_DONE;
            c_d     = res;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      w_q     <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      opnd_q  <= '0;
      shf_q   <= '0;
      acc_q   <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      w_q     <= w_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      opnd_q  <= opnd_d;
      shf_q   <= shf_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
    end
  end

  assign c = c_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed RV64M vectors against literals, plus an arithmetic
// reference model compared with the outputs on every cycle.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in = 1'b0;
  logic        is_32instr = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        ready_out, done;
  logic [63:0] c;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  muldiv_seq #(.XLEN(64), .CNT_W(7)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out),
    .op(op), .is_32instr(is_32instr), .a(a), .b(b), .flush(flush),
    .done(done), .c(c)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference arithmetic straight from the RV64M definitions
  function automatic logic [63:0] model_res(input logic [2:0] o, input logic w,
                                            input logic [63:0] x, input logic [63:0] y);
    logic signed [127:0] px, py, pp;
    logic signed [63:0]  sx, sy;
    logic signed [31:0]  sx32, sy32;
    logic [31:0]         r32;
    logic [63:0]         r;
    if (!o[2]) begin
      if (w) begin
        r32 = x[31:0] * y[31:0];
        return {{32{r32[31]}}, r32};
      end
      px = (o == 3'd1 || o == 3'd2) ? $signed({{64{x[63]}}, x}) : $signed({64'd0, x});
      py = (o == 3'd1) ? $signed({{64{y[63]}}, y}) : $signed({64'd0, y});
      pp = px * py;
      return (o == 3'd0) ? pp[63:0] : pp[127:64];
    end
    if (w) begin
      sx32 = x[31:0];
      sy32 = y[31:0];
      if (y[31:0] == 32'd0)     r32 = o[1] ? x[31:0] : 32'hFFFF_FFFF;
      else if (o[0])            r32 = o[1] ? x[31:0] % y[31:0] : x[31:0] / y[31:0];
      else if (x[31:0] == 32'h8000_0000 && y[31:0] == 32'hFFFF_FFFF)
                                r32 = o[1] ? 32'd0 : x[31:0];
      else                      r32 = o[1] ? sx32 % sy32 : sx32 / sy32;
      return {{32{r32[31]}}, r32};
    end
    sx = x;
    sy = y;
    if (y == 64'd0)             r = o[1] ? x : '1;
    else if (o[0])              r = o[1] ? x % y : x / y;
    else if (x == 64'h8000_0000_0000_0000 && y == '1) r = o[1] ? 64'd0 : x;
    else                        r = o[1] ? sx % sy : sx / sy;
    return r;
  endfunction

  function automatic int model_lat(input logic [2:0] o, input logic w,
                                   input logic [63:0] x, input logic [63:0] y);
    logic zero, ovf;
    if (!o[2]) return w ? 33 : 65;
    zero = w ? (y[31:0] == 32'd0) : (y == 64'd0);
    ovf  = !o[0] && (w ? (x[31:0] == 32'h8000_0000 && y[31:0] == 32'hFFFF_FFFF)
                       : (x == 64'h8000_0000_0000_0000 && y == '1));
    return (zero || ovf) ? 1 : (w ? 33 : 65);
  endfunction

  // m_left: cycles still to spend not-ready, the last of which is the done cycle
  int          m_left = 0;
  int          lat_now;
  logic [63:0] m_c = '0, m_pend = '0, res_now;

  always_comb begin
    lat_now = model_lat(op, is_32instr, a, b);
    res_now = model_res(op, is_32instr, a, b);
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_left <= 0;
      m_c    <= '0;
      m_pend <= '0;
    end else if (m_left == 0) begin
      if (valid_in && !flush) begin
        m_left <= lat_now;
        m_pend <= res_now;
        if (lat_now == 1) m_c <= res_now;
      end
    end else if (flush) begin
      m_left <= 0;
    end else begin
      m_left <= m_left - 1;
      if (m_left == 2) m_c <= m_pend;
    end
  end

  bit   chk_en = 1'b0;
  logic prev_done = 1'b0;

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      chk("ready_out", {63'd0, ready_out}, {63'd0, m_left == 0});
      chk("done", {63'd0, done}, {63'd0, (m_left == 1) && !flush});
      chk("c", c, m_c);
      if (done) chk("done_back_to_back", {63'd0, prev_done}, 64'd0);
      prev_done = done;
    end
  end

  task automatic run_op(input string name, input logic [2:0] o, input logic w,
                        input logic [63:0] x, input logic [63:0] y,
                        input logic [63:0] exp_c, input int exp_lat);
    int cyc;
    chk({name, "_model"}, model_res(o, w, x, y), exp_c);
    @(posedge clk); #1;
    op = o; is_32instr = w; a = x; b = y; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    cyc = 1;
    while (cyc < 200) begin
      @(negedge clk);
      if (done) break;
      cyc++;
    end
    chk({name, "_lat"}, 64'(cyc), 64'(exp_lat));
    chk({name, "_c"}, c, exp_c);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {63'd0, ready_out}, 64'd1);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_c", c, 64'd0);
    reset  = 1'b0;
    chk_en = 1'b1;

    run_op("mul",     3'd0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 65);
    run_op("mulhu",   3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    run_op("mulh",    3'd1, 1'b0, '1, '1, 64'd0, 65);
    run_op("mulhsu",  3'd2, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op("div",     3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run_op("rem",     3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op("divu",    3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65);
    run_op("div_z",   3'd4, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("rem_z",   3'd6, 1'b0, 64'd5, 64'd0, 64'd5, 1);
    run_op("divw_ov", 3'd4, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
    run_op("remw_ov", 3'd6, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1);
    run_op("divuw",   3'd5, 1'b1, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33);
    run_op("mulw",    3'd0, 1'b1, 64'h1_0000, 64'h1_0000, 64'd0, 33);
    run_op("mulw_ng", 3'd0, 1'b1, 64'hFFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 33);
    run_op("divw",    3'd4, 1'b1, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33);
    run_op("remuw",   3'd7, 1'b1, 64'h8000_0000, 64'd3, 64'd2, 33);
    run_op("remu",    3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 65);

    // Abort a divide in its tenth cycle
    @(posedge clk); #1;
    op = 3'd4; is_32instr = 1'b0; a = 64'hFFFF_FFFF_FFFF_FFF9; b = 64'd2; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_ready", {63'd0, ready_out}, 64'd1);
    chk("flush_done", {63'd0, done}, 64'd0);
    chk("flush_c_kept", c, 64'd2);
    run_op("mul_after_flush", 3'd0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 65);

    // A request presented together with flush in IDLE is dropped
    @(posedge clk); #1;
    op = 3'd4; a = 64'd5; b = 64'd0; valid_in = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0; flush = 1'b0;
    chk("idle_flush_ready", {63'd0, ready_out}, 64'd1);
    @(negedge clk);
    chk("idle_flush_done", {63'd0, done}, 64'd0);
    chk("idle_flush_c", c, 64'hFFFF_FFFF_FFFF_FFF1);

    // Asynchronous reset in the middle of a multiply
    @(posedge clk); #1;
    op = 3'd3; a = '1; b = '1; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (19) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst_ready", {63'd0, ready_out}, 64'd1);
    chk("async_rst_done", {63'd0, done}, 64'd0);
    chk("async_rst_c", c, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    run_op("divu_after_rst", 3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65);

    repeat (3) @(posedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
